// File: rtl/deser_pkg.sv
// Shared types and helpers for the serial deserializer.
// Assembly and output-buffer state encodings plus counter sizing.
package deser_pkg;

  typedef enum logic {
    IDLE,
    SHIFT
  } asm_state_t;

  typedef enum logic {
    EMPTY,
    FULL
  } buf_state_t;

  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/deser_outbuf.sv
// Single-entry valid/ready holding register for assembled words.
// Loads on completion when free or drained; otherwise drops and flags overrun.
module deser_outbuf
  import deser_pkg::*;
#(
  parameter int N = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [N-1:0] din,
  input  logic         ready,
  input  logic         clr_overrun,
  output logic [N-1:0] dout,
  output logic         valid,
  output logic         overrun
);

  buf_state_t st;
  logic       accept;
  logic       drop;
  logic       drain;

  assign accept = (st == EMPTY) || ready;
  assign drop   = load && !accept;
  assign drain  = !load && (st == FULL) && ready;
  assign valid  = (st == FULL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st      <= EMPTY;
      dout    <= '0;
      overrun <= 1'b0;
    end else begin
      unique case (1'b1)
        load && accept: begin
          st   <= FULL;
          dout <= din;
        end
        drain: st <= EMPTY;
        default: ;
      endcase
      // a drop in the same cycle beats a clear
      if (drop) begin
        overrun <= 1'b1;
      end else if (clr_overrun) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/serial_deserializer.sv
// Serial-to-parallel word assembler with a valid/ready output buffer.
// Assembly FSM and shifter live here; the holding register is deser_outbuf.
module serial_deserializer
  import deser_pkg::*;
#(
  parameter int N         = 6,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         sin_valid,
  input  logic         sin_bit,
  input  logic         sin_start,
  output logic [N-1:0] word_out,
  output logic         word_valid,
  input  logic         word_ready,
  output logic         busy,
  output logic         overrun,
  input  logic         clr_overrun
);

  localparam int CW = cnt_width(N);

  asm_state_t    state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_base;
  logic [N-1:0]  sh;
  logic [N-1:0]  sh_nxt;
  logic          done;

  // stale bits are shifted out before a word can complete
  always_comb begin
    cnt_base = sin_start ? '0 : cnt;
    if (MSB_FIRST) begin
      sh_nxt = {sh[N-2:0], sin_bit};
    end else begin
      sh_nxt = {sin_bit, sh[N-1:1]};
    end
    done = sin_valid && (cnt_base == CW'(N - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      sh    <= '0;
    end else if (sin_valid) begin
      sh <= sh_nxt;
      if (done) begin
        state <= IDLE;
        cnt   <= '0;
      end else begin
        state <= SHIFT;
        cnt   <= cnt_base + CW'(1);
      end
    end
  end

  assign busy = (state == SHIFT);

  deser_outbuf #(
    .N(N)
  ) u_outbuf (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (done),
    .din        (sh_nxt),
    .ready      (word_ready),
    .clr_overrun(clr_overrun),
    .dout       (word_out),
    .valid      (word_valid),
    .overrun    (overrun)
  );

endmodule

// File: tb/tb_serial_deserializer.sv
// Directed bench for serial_deserializer, MSB-first and LSB-first instances.
// Table rows cover basic assembly and overrun; tasks cover multi-cycle cases.
module tb_serial_deserializer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sin_valid, sin_bit, sin_start;
  logic       word_ready, clr_overrun;
  logic [5:0] word_m, word_l;
  logic       valid_m, valid_l, busy_m, busy_l, ovr_m, ovr_l;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  serial_deserializer #(.N(6), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .rst_n(rst_n), .sin_valid(sin_valid), .sin_bit(sin_bit),
    .sin_start(sin_start), .word_out(word_m), .word_valid(valid_m),
    .word_ready(word_ready), .busy(busy_m), .overrun(ovr_m),
    .clr_overrun(clr_overrun)
  );

  serial_deserializer #(.N(6), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst_n(rst_n), .sin_valid(sin_valid), .sin_bit(sin_bit),
    .sin_start(sin_start), .word_out(word_l), .word_valid(valid_l),
    .word_ready(word_ready), .busy(busy_l), .overrun(ovr_l),
    .clr_overrun(clr_overrun)
  );

  typedef struct {
    logic       v, s, b, r, c;
    logic       ev;
    logic [5:0] em, el;
    logic       eb, eo;
  } vec_t;

  localparam int NV = 21;
  vec_t tbl [0:NV-1];

  task automatic chk(input string nm, input logic [7:0] act,
                     input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc(input logic v, input logic s, input logic b,
                     input logic r, input logic c);
    sin_valid   = v;
    sin_start   = s;
    sin_bit     = b;
    word_ready  = r;
    clr_overrun = c;
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [5:0] p, input logic r,
                           input logic c);
    for (int i = 0; i < 6; i++) cyc(1'b1, 1'b0, p[5-i], r, c);
  endtask

  initial begin
    logic [5:0] pat;
    logic [5:0] words [0:2];

    // v s b r c | ev  em     el     eb eo
    tbl[0]  = '{1,0,1,1,0, 0, 6'h00, 6'h00, 1, 0};
    tbl[1]  = '{1,0,1,1,0, 0, 6'h00, 6'h00, 1, 0};
    tbl[2]  = '{1,0,0,1,0, 0, 6'h00, 6'h00, 1, 0};
    tbl[3]  = '{1,0,0,1,0, 0, 6'h00, 6'h00, 1, 0};
    tbl[4]  = '{1,0,1,1,0, 0, 6'h00, 6'h00, 1, 0};
    tbl[5]  = '{1,0,0,1,0, 1, 6'h32, 6'h13, 0, 0};
    tbl[6]  = '{0,0,0,1,0, 0, 6'h32, 6'h13, 0, 0};
    tbl[7]  = '{1,0,1,0,0, 0, 6'h32, 6'h13, 1, 0};
    tbl[8]  = '{1,0,1,0,0, 0, 6'h32, 6'h13, 1, 0};
    tbl[9]  = '{1,0,0,0,0, 0, 6'h32, 6'h13, 1, 0};
    tbl[10] = '{1,0,0,0,0, 0, 6'h32, 6'h13, 1, 0};
    tbl[11] = '{1,0,1,0,0, 0, 6'h32, 6'h13, 1, 0};
    tbl[12] = '{1,0,0,0,0, 1, 6'h32, 6'h13, 0, 0};
    tbl[13] = '{1,0,0,0,0, 1, 6'h32, 6'h13, 1, 0};
    tbl[14] = '{1,0,0,0,0, 1, 6'h32, 6'h13, 1, 0};
    tbl[15] = '{1,0,1,0,0, 1, 6'h32, 6'h13, 1, 0};
    tbl[16] = '{1,0,1,0,0, 1, 6'h32, 6'h13, 1, 0};
    tbl[17] = '{1,0,1,0,0, 1, 6'h32, 6'h13, 1, 0};
    tbl[18] = '{1,0,1,0,0, 1, 6'h32, 6'h13, 0, 1};
    tbl[19] = '{0,0,0,1,0, 0, 6'h32, 6'h13, 0, 1};
    tbl[20] = '{0,0,0,0,1, 0, 6'h32, 6'h13, 0, 0};

    rst_n = 1'b0;
    sin_valid = 1'b0; sin_bit = 1'b0; sin_start = 1'b0;
    word_ready = 1'b0; clr_overrun = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst valid", {7'd0, valid_m}, 8'd0);
    chk("rst word", {2'd0, word_m}, 8'd0);
    chk("rst busy", {7'd0, busy_m}, 8'd0);
    chk("rst ovr", {7'd0, ovr_m}, 8'd0);
    chk("rst word_l", {2'd0, word_l}, 8'd0);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      cyc(tbl[i].v, tbl[i].s, tbl[i].b, tbl[i].r, tbl[i].c);
      chk($sformatf("tbl%0d valid", i), {7'd0, valid_m}, {7'd0, tbl[i].ev});
      chk($sformatf("tbl%0d valid_l", i), {7'd0, valid_l}, {7'd0, tbl[i].ev});
      chk($sformatf("tbl%0d word", i), {2'd0, word_m}, {2'd0, tbl[i].em});
      chk($sformatf("tbl%0d word_l", i), {2'd0, word_l}, {2'd0, tbl[i].el});
      chk($sformatf("tbl%0d busy", i), {7'd0, busy_m}, {7'd0, tbl[i].eb});
      chk($sformatf("tbl%0d ovr", i), {7'd0, ovr_m}, {7'd0, tbl[i].eo});
    end

    // three-cycle gaps between bits
    pat = 6'h32;
    for (int i = 0; i < 6; i++) begin
      cyc(1'b1, 1'b0, pat[5-i], 1'b1, 1'b0);
      chk("gap busy", {7'd0, busy_m}, {7'd0, i < 5});
      chk("gap valid", {7'd0, valid_m}, {7'd0, i == 5});
      if (i < 5) begin
        for (int g = 0; g < 3; g++) begin
          cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
          chk("gap stall busy", {7'd0, busy_m}, 8'd1);
          chk("gap stall valid", {7'd0, valid_m}, 8'd0);
        end
      end
    end
    chk("gap word", {2'd0, word_m}, 8'h32);
    chk("gap word_l", {2'd0, word_l}, 8'h13);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("gap drain", {7'd0, valid_m}, 8'd0);

    // restart after a 4-bit partial word
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
      chk("part valid", {7'd0, valid_m}, 8'd0);
    end
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("start valid", {7'd0, valid_m}, 8'd0);
    chk("start busy", {7'd0, busy_m}, 8'd1);
    pat = 6'b001010;
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 1'b0, pat[4-i], 1'b1, 1'b0);
      chk("restart valid", {7'd0, valid_m}, {7'd0, i == 4});
    end
    chk("restart word", {2'd0, word_m}, 8'h2A);
    chk("restart word_l", {2'd0, word_l}, 8'h15);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // full-rate back-to-back words
    words[0] = 6'h32; words[1] = 6'h0F; words[2] = 6'h2A;
    for (int w = 0; w < 3; w++) begin
      pat = words[w];
      for (int i = 0; i < 6; i++) begin
        cyc(1'b1, 1'b0, pat[5-i], 1'b1, 1'b0);
        chk("b2b valid", {7'd0, valid_m}, {7'd0, i == 5});
        chk("b2b ovr", {7'd0, ovr_m}, 8'd0);
      end
      chk("b2b word", {2'd0, word_m}, {2'd0, pat});
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // completion and consume in the same cycle
    send_word(6'h0F, 1'b0, 1'b0);
    chk("hold valid", {7'd0, valid_m}, 8'd1);
    chk("hold word", {2'd0, word_m}, 8'h0F);
    pat = 6'h32;
    for (int i = 0; i < 6; i++) cyc(1'b1, 1'b0, pat[5-i], i == 5, 1'b0);
    chk("swap valid", {7'd0, valid_m}, 8'd1);
    chk("swap word", {2'd0, word_m}, 8'h32);
    chk("swap ovr", {7'd0, ovr_m}, 8'd0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("swap drain", {7'd0, valid_m}, 8'd0);

    // overrun set beats a simultaneous clear
    send_word(6'h2A, 1'b0, 1'b0);
    send_word(6'h0F, 1'b0, 1'b1);
    chk("setwin ovr", {7'd0, ovr_m}, 8'd1);
    chk("setwin word", {2'd0, word_m}, 8'h2A);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("clr ovr", {7'd0, ovr_m}, 8'd0);
    chk("clr valid", {7'd0, valid_m}, 8'd0);

    // asynchronous reset mid-word with the buffer full
    send_word(6'h32, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("pre-rst valid", {7'd0, valid_m}, 8'd1);
    chk("pre-rst busy", {7'd0, busy_m}, 8'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst valid", {7'd0, valid_m}, 8'd0);
    chk("arst word", {2'd0, word_m}, 8'd0);
    chk("arst busy", {7'd0, busy_m}, 8'd0);
    chk("arst ovr", {7'd0, ovr_m}, 8'd0);
    chk("arst word_l", {2'd0, word_l}, 8'd0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("post-rst valid", {7'd0, valid_m}, 8'd0);
    chk("post-rst busy", {7'd0, busy_m}, 8'd0);
    send_word(6'h2D, 1'b1, 1'b0);
    chk("post-rst word", {2'd0, word_m}, 8'h2D);
    chk("post-rst word_l", {2'd0, word_l}, 8'h2D);
    chk("post-rst wvalid", {7'd0, valid_m}, 8'd1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("post-rst drain", {7'd0, valid_m}, 8'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_deserializer.md
# serial_deserializer

Serial-to-parallel front end that assembles an N-bit word from a one-bit-per-cycle input stream and presents it on a valid/ready output buffer. It sits directly upstream of the N-bit word register: `word_out` drives the register's `D`. The buffer holds `word_out` stable until the word is consumed. Word completions that arrive while the buffer is still full are dropped and flagged.

## Interface
- `N`, default 6: word width in bits; legal range N ≥ 2.
- `MSB_FIRST`, default 1: 1 = first received bit lands in bit N-1; 0 = first received bit lands in bit 0.

- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `sin_valid` input 1: `sin_bit` is meaningful this cycle.
- `sin_bit` input 1: serial data bit.
- `sin_start` input 1: frame start, qualified by `sin_valid`. The current bit becomes bit #1 of a new word and any partial word is discarded.
- `word_out` output N: assembled word, stable while `word_valid` = 1.
- `word_valid` output 1: output buffer holds an unconsumed word.
- `word_ready` input 1: consumer accepts `word_out` this cycle.
- `busy` output 1: a partial word is in the shift register.
- `overrun` output 1: sticky; set when a completed word was dropped.
- `clr_overrun` input 1: synchronous clear of `overrun`.

## Operation
- Assembly state machine, IDLE/SHIFT, with bit counter `cnt` of width clog2(N+1).
  - IDLE: `cnt`=0. An accepted bit (`sin_valid`=1) moves to SHIFT with `cnt`=1.
  - SHIFT: each accepted bit increments `cnt`.
  - Nth accepted bit: the word completes, the state returns to IDLE and `cnt` returns to 0.
  - `sin_start`&`sin_valid` in any state: partial word discarded, `cnt`=1, state SHIFT.
  - `sin_start` with `sin_valid`=0 is ignored.
  - `sin_valid`=0 cycles stall assembly without loss.
- Shift rule:
  - MSB_FIRST=1: `sh <= {sh[N-2:0], sin_bit}`.
  - MSB_FIRST=0: `sh <= {sin_bit, sh[N-1:1]}`.
  - The completed word is the post-shift value.
- Output buffer, EMPTY/FULL, tracked by `word_valid`:
  - A completed word loads the buffer when the buffer is EMPTY, or FULL with `word_ready`=1 this cycle. `word_valid` is 1 next cycle.
  - Completion while FULL and `word_ready`=0: the new word is dropped, the buffer is unchanged and `overrun` is set.
  - `word_ready`=1 with `word_valid`=1 and no completion: the buffer goes EMPTY next cycle.
  - `word_ready` while EMPTY has no effect.
- `overrun`: set wins over `clr_overrun` in the same cycle.
- `busy` = (state == SHIFT).

## Timing
- Reset values: `word_out`=0, `word_valid`=0, `busy`=0, `overrun`=0, state IDLE, `cnt`=0, `sh`=0.
- Reset asserted mid-word or with the buffer FULL: all state clears immediately (asynchronous). Nothing is output after release.
- Latency: `word_valid` rises on the clock edge that samples the Nth bit, so the word is visible the cycle after the Nth bit is presented.
- Back-to-back words at full rate (`sin_valid` held 1, `word_ready` held 1): one word every N cycles, no bubbles, no overrun.
- Completion and consume in the same cycle: `word_valid` stays 1 and `word_out` takes the new word.
- `word_out` changes only on a buffer load.

## Structure
- Shared package `deser_pkg`:
  - assembly state enum {IDLE, SHIFT};
  - output buffer state enum {EMPTY, FULL};
  - function computing counter width from N.
- One sub-module, `deser_outbuf`: a single-entry valid/ready holding register with load/drop/overrun logic.
- The assembly FSM and shifter live in the top level.

## Test plan
- Reset, then N=6, MSB_FIRST=1, bits 1,1,0,0,1,0 on consecutive cycles, `word_ready`=1 -> `word_out`=6'h32, `word_valid` high for exactly 1 cycle, the cycle after the 6th bit.
- Same stream with MSB_FIRST=0 -> `word_out`=6'h13.
- `sin_valid` gaps of 3 cycles between bits -> same word; `busy` high from the 1st bit through the 5th bit.
- `sin_start` with bit 1 after 4 bits of a word, then 5 more bits 0,1,0,1,0 (MSB_FIRST=1) -> `word_out`=6'h2A; the partial word is never output.
- `word_ready`=0, two full words 6'h32 then 6'h0F -> `word_out` stays 6'h32 and `overrun`=1. Then `word_ready`=1 for one cycle -> `word_valid` 0. `clr_overrun` -> `overrun` 0.
- `rst_n` low after 3 bits with the buffer FULL -> all outputs 0 at once. After release, 6 bits 1,0,1,1,0,1 -> 6'h2D.
